// File: rtl/iopw_pkg.sv
// Shared types and defaults for the posted I/O write buffer.
// One FIFO entry holds address, data and active-high byte strobes.
package iopw_pkg;

  localparam int IOPW_DEPTH = 4;
  localparam int IOPW_AW    = 23;
  localparam int IOPW_DW    = 16;

  typedef struct packed {
    logic [IOPW_AW-1:0] addr;
    logic [IOPW_DW-1:0] data;
    logic [1:0]         bs;
  } pw_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pw_fifo.sv
// Synchronous FIFO of posted-write entries.
// Pointers wrap naturally because DEPTH is a power of two.
module pw_fifo
  import iopw_pkg::*;
#(
  parameter int DEPTH = IOPW_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  pw_entry_t              wdata,
  output pw_entry_t              rdata,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_N = (PW+1)'(DEPTH);

  pw_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == FULL_N);
  assign empty = (count == '0);

  // A push into a full FIFO is legal only when a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/iopw_buffer.sv
// Posted-write buffer: captures postable CPU writes, acks at once,
// and drains them to the I/O bus engine over IOREQ/IOACK.
module iopw_buffer
  import iopw_pkg::*;
#(
  parameter int DEPTH = IOPW_DEPTH,
  parameter int AW    = IOPW_AW,
  parameter int DW    = IOPW_DW
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          BACT,
  input  logic          IOPWCS,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic          nUDS,
  input  logic          nLDS,
  output logic          PWReady,
  output logic          PWEmpty,
  output logic          PWFull,
  output logic          IOREQ,
  input  logic          IOACK,
  output logic [AW-1:0] IOA,
  output logic [DW-1:0] IOD,
  output logic [1:0]    IOBS
);

  localparam int PW = ptr_w(DEPTH);

  logic             done;
  logic             push;
  logic             pop;
  pw_entry_t        wr_entry;
  pw_entry_t        head;
  logic [PW:0]      count;
  logic             full;
  logic             empty;

  assign pop  = IOREQ & IOACK;
  assign push = BACT & IOPWCS & ~done & (~full | pop);

  assign wr_entry.addr = A;
  assign wr_entry.data = D;
  assign wr_entry.bs   = {~nUDS, ~nLDS};

  // One capture per bus cycle; the flag doubles as the CPU ready.
  always_ff @(posedge CLK) begin
    if (RES)        done <= 1'b0;
    else if (!BACT) done <= 1'b0;
    else if (push)  done <= 1'b1;
  end

  pw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RES),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign PWReady = done;
  assign PWEmpty = empty;
  assign PWFull  = full;
  assign IOREQ   = (count != '0);

  // Head is blanked when idle so stale storage never shows on the bus.
  assign IOA  = IOREQ ? head.addr : '0;
  assign IOD  = IOREQ ? head.data : '0;
  assign IOBS = IOREQ ? head.bs   : 2'b00;

endmodule

// File: tb/tb_iopw_buffer.sv
// Scoreboard bench for iopw_buffer: expected entries are queued as
// writes are driven and compared when the engine acks the head.
module tb_iopw_buffer;
  import iopw_pkg::*;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        BACT = 1'b0;
  logic        IOPWCS = 1'b0;
  logic [22:0] A = '0;
  logic [15:0] D = '0;
  logic        nUDS = 1'b1;
  logic        nLDS = 1'b1;
  logic        PWReady, PWEmpty, PWFull, IOREQ;
  logic        IOACK = 1'b0;
  logic [22:0] IOA;
  logic [15:0] IOD;
  logic [1:0]  IOBS;

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;
  pw_entry_t exp_q[$];

  iopw_buffer dut (
    .CLK(CLK), .RES(RES), .BACT(BACT), .IOPWCS(IOPWCS),
    .A(A), .D(D), .nUDS(nUDS), .nLDS(nLDS),
    .PWReady(PWReady), .PWEmpty(PWEmpty), .PWFull(PWFull),
    .IOREQ(IOREQ), .IOACK(IOACK),
    .IOA(IOA), .IOD(IOD), .IOBS(IOBS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Inputs change just after posedge, so negedge sees next-edge values.
  always @(negedge CLK) begin
    if (!RES && IOREQ && IOACK) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'd1, 64'd0);
      end else begin
        pw_entry_t e;
        e = exp_q.pop_front();
        chk("pop_entry", {23'd0, IOA, IOD, IOBS},
            {23'd0, e.addr, e.data, e.bs});
      end
    end
  end

  task automatic set_write(input logic [22:0] a, input logic [15:0] d,
                           input logic ub, input logic lb);
    pw_entry_t e;
    BACT = 1'b1; IOPWCS = 1'b1;
    A = a; D = d; nUDS = ub; nLDS = lb;
    e.addr = a; e.data = d; e.bs = {~ub, ~lb};
    exp_q.push_back(e);
  endtask

  task automatic cpu_write(input logic [22:0] a, input logic [15:0] d,
                           input logic ub, input logic lb);
    int i;
    set_write(a, d, ub, lb);
    for (i = 0; i < 8; i++) begin
      tick();
      if (PWReady) break;
    end
    chk("cap_ready", 64'(PWReady), 64'd1);
    BACT = 1'b0; IOPWCS = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag, input int n);
    int start, cyc;
    start = pops;
    cyc = 0;
    IOACK = 1'b1;
    while (IOREQ && cyc < 20) begin
      tick();
      cyc++;
    end
    IOACK = 1'b0;
    chk({tag, "_pops"}, 64'(pops - start), 64'(n));
    chk({tag, "_cycles"}, 64'(cyc), 64'(n));
    chk({tag, "_ioreq"}, 64'(IOREQ), 64'd0);
  endtask

  initial begin
    tick(); tick();
    RES = 1'b0;
    chk("rst_empty", 64'(PWEmpty), 64'd1);
    chk("rst_full",  64'(PWFull), 64'd0);
    chk("rst_ioreq", 64'(IOREQ), 64'd0);
    chk("rst_ready", 64'(PWReady), 64'd0);
    chk("rst_head",  {23'd0, IOA, IOD, IOBS}, 64'd0);

    // single write
    set_write(23'h1FA100, 16'hBEEF, 1'b0, 1'b0);
    tick();
    chk("sw_ready", 64'(PWReady), 64'd1);
    chk("sw_ioreq", 64'(IOREQ), 64'd1);
    chk("sw_ioa",   64'(IOA), 64'h1FA100);
    chk("sw_iod",   64'(IOD), 64'hBEEF);
    chk("sw_iobs",  64'(IOBS), 64'd3);
    BACT = 1'b0; IOPWCS = 1'b0; IOACK = 1'b1;
    tick();
    IOACK = 1'b0;
    chk("sw_ioreq_off", 64'(IOREQ), 64'd0);
    chk("sw_empty",     64'(PWEmpty), 64'd1);
    chk("sw_ready_off", 64'(PWReady), 64'd0);

    // long BACT: one capture only
    set_write(23'h000100, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("long_ready", 64'(PWReady), 64'd1);
    BACT = 1'b0; IOPWCS = 1'b0;
    tick();
    drain("long", 1);

    // fill and stall
    for (int i = 1; i <= 4; i++)
      cpu_write(23'(32'h10 + i), 16'(i), 1'b0, 1'b0);
    chk("fill_full", 64'(PWFull), 64'd1);
    set_write(23'h15, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 64'(PWReady), 64'd0);
    end
    IOACK = 1'b1;
    tick();
    IOACK = 1'b0;
    chk("stall_cap", 64'(PWReady), 64'd1);
    chk("stall_full", 64'(PWFull), 64'd1);
    BACT = 1'b0; IOPWCS = 1'b0;
    tick();
    drain("fill", 4);

    // continuous drain of three
    for (int i = 0; i < 3; i++)
      cpu_write(23'(32'h200 + i), 16'(32'hA0 + i), 1'b0, 1'b0);
    drain("cont", 3);
    chk("cont_empty", 64'(PWEmpty), 64'd1);

    // byte strobes
    set_write(23'h3ABCD, 16'h5A5A, 1'b1, 1'b0);
    tick();
    chk("bs_iobs", 64'(IOBS), 64'd1);
    BACT = 1'b0; IOPWCS = 1'b0;
    tick();
    drain("bs", 1);

    // reset mid-drain
    for (int i = 0; i < 3; i++)
      cpu_write(23'(32'h300 + i), 16'(32'hC0 + i), 1'b0, 1'b0);
    RES = 1'b1;
    exp_q.delete();
    tick();
    RES = 1'b0;
    chk("mrst_empty", 64'(PWEmpty), 64'd1);
    chk("mrst_ioreq", 64'(IOREQ), 64'd0);
    chk("mrst_ready", 64'(PWReady), 64'd0);
    begin
      int p0;
      p0 = pops;
      IOACK = 1'b1;
      tick();
      IOACK = 1'b0;
      chk("mrst_ack_pops", 64'(pops - p0), 64'd0);
    end
    chk("mrst_empty2", 64'(PWEmpty), 64'd1);
    chk("mrst_ioreq2", 64'(IOREQ), 64'd0);
    chk("sb_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
